// File: rtl/fifo8.sv
// fifo8: eight-entry synchronous FIFO with show-ahead read data.
// The head word is presented combinationally whenever the FIFO is non-empty.
// Overflow/underflow are sticky until reset.
module fifo8 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             udf
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [AW-1:0]    wr_ptr_nxt;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count_nxt;

  // Status flags decode the count register only, never the request inputs.
  always_comb begin
    full  = (count == (AW+1)'(DEPTH));
    empty = (count == '0);
  end

  // Accept logic, pointer increments (natural wrap at DEPTH) and count update.
  always_comb begin
    wr_acc     = wr_en & ~full;
    rd_acc     = rd_en & ~empty;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (wr_acc) wr_ptr_nxt = wr_ptr + AW'(1);
    if (rd_acc) rd_ptr_nxt = rd_ptr + AW'(1);
    if (wr_acc && !rd_acc)      count_nxt = count + (AW+1)'(1);
    else if (rd_acc && !wr_acc) count_nxt = count - (AW+1)'(1);
  end

  // Control state: pointers, count and sticky error flags, async cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (wr_en && full)  ovf <= 1'b1;
      if (rd_en && empty) udf <= 1'b1;
    end
  end

  // Storage array: written only on an accepted write, never reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // Show-ahead read port: head word through the read-pointer mux.
  always_comb begin
    rd_data = mem[rd_ptr];
  end

endmodule
